// File: rtl/axis_i2c_slave.sv
// I2C target (7-bit address) bridged to AXI-Stream.
// Bytes written by the I2C controller leave on the m_* master port.
// Bytes read by the I2C controller are taken from the s_* slave port.
//
// Handshake rule for both AXIS ports: a beat transfers on a rising clk_i edge
// where tvalid and tready are both high. A raised tvalid is held, with tdata
// stable, until that edge. tready may be asserted or withdrawn at any time.
module axis_i2c_slave #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  busy_o,
  output logic [2:0]            debug_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shreg_q, shreg_d;
  logic       rw_q, rw_d;
  logic       ack_phase_q, ack_phase_d;  // first falling edge of an ACK slot already seen
  logic       ack_ok_q, ack_ok_d;
  logic [7:0] rd_byte_q, rd_byte_d;
  logic [7:0] m_byte_q, m_byte_d;
  logic       sda_oe_d, m_tvalid_d, s_tready_d;
  logic       load_rd;
  logic [7:0] in_byte;

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Upper tdata bits carry nothing on the I2C side.
  logic unused_tdata;
  assign unused_tdata = ^s_tdata;

  // Two-flop synchronizers followed by a history flop for edge detection.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      scl_meta <= 1'b1; scl_sync <= 1'b1; scl_prev <= 1'b1;
      sda_meta <= 1'b1; sda_sync <= 1'b1; sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl_i; scl_sync <= scl_meta; scl_prev <= scl_sync;
      sda_meta <= sda_i; sda_sync <= sda_meta; sda_prev <= sda_sync;
    end
  end

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & ~sda_sync & sda_prev;
  assign stop_det  = scl_sync & scl_prev & sda_sync & ~sda_prev;
  assign in_byte   = {shreg_q, sda_sync};

  assign m_tdata     = DATA_WIDTH'(m_byte_q);
  assign busy_o      = (state_q == ADDR_ACK) || (state_q == WR_DATA) || (state_q == WR_ACK) ||
                       (state_q == RD_DATA)  || (state_q == RD_ACK);
  assign debug_state = state_q;

  // State and datapath registers; reset releases SDA at once.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      ack_ok_q    <= 1'b0;
      rd_byte_q   <= '0;
      m_byte_q    <= '0;
      sda_oe_o    <= 1'b0;
      m_tvalid    <= 1'b0;
      s_tready    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      ack_phase_q <= ack_phase_d;
      ack_ok_q    <= ack_ok_d;
      rd_byte_q   <= rd_byte_d;
      m_byte_q    <= m_byte_d;
      sda_oe_o    <= sda_oe_d;
      m_tvalid    <= m_tvalid_d;
      s_tready    <= s_tready_d;
    end
  end

  // Next-state and output decisions, driven by synchronized SCL/SDA events.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    ack_phase_d = ack_phase_q;
    ack_ok_d    = ack_ok_q;
    rd_byte_d   = rd_byte_q;
    m_byte_d    = m_byte_q;
    sda_oe_d    = sda_oe_o;
    m_tvalid_d  = m_tvalid;
    s_tready_d  = 1'b0;
    load_rd     = 1'b0;

    if (m_tvalid && m_tready) m_tvalid_d = 1'b0;

    if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shreg_d = in_byte[6:0];
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d   = '0;
            rw_d        = in_byte[0];
            ack_phase_d = 1'b0;
            state_d     = (in_byte[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d    = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            ack_phase_d = 1'b0;
            if (rw_q) begin
              load_rd = 1'b1;
              state_d = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_d = in_byte[6:0];
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d   = '0;
            ack_phase_d = 1'b0;
            state_d     = WR_ACK;
            // Accept only if the output register is free this cycle.
            if (!m_tvalid || m_tready) begin
              m_byte_d   = in_byte;
              m_tvalid_d = 1'b1;
              ack_ok_d   = 1'b1;
            end else begin
              ack_ok_d   = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d    = ack_ok_q;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            state_d     = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d    = 1'b0;
              bit_cnt_d   = '0;
              ack_phase_d = 1'b0;
              state_d     = RD_ACK;
            end else begin
              sda_oe_d = ~rd_byte_q[3'(4'd7 - bit_cnt_q)];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_sync) state_d = IGNORE;
            else          ack_phase_d = 1'b1;
          end else if (scl_fall && ack_phase_q) begin
            ack_phase_d = 1'b0;
            load_rd     = 1'b1;
            state_d     = RD_DATA;
          end
        end
        default: sda_oe_d = 1'b0;  // IDLE and IGNORE keep SDA released
      endcase
    end

    // Fetch the next read byte and put its MSB on the bus.
    if (load_rd) begin
      bit_cnt_d = '0;
      if (s_tvalid) begin
        rd_byte_d  = s_tdata[7:0];
        s_tready_d = 1'b1;
        sda_oe_d   = ~s_tdata[7];
      end else begin
        rd_byte_d  = 8'hFF;
        sda_oe_d   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_i2c_slave.sv
// Directed bench for axis_i2c_slave: I2C controller model, AXIS monitors,
// table of write transactions plus hand-written read/corner sequences.
module tb_axis_i2c_slave;

  localparam int         Q        = 8;   // clk cycles per quarter SCL period
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd5;
  localparam logic [2:0] ST_IGN   = 3'd7;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int treadies = 0;
  int oe_cycles = 0;
  logic [7:0] last_beat = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Open-drain bus: controller and target both pull low.
  assign sda_bus = sda_m & ~sda_oe;

  axis_i2c_slave #(.DATA_WIDTH(8), .SLAVE_ADDR(7'h50)) dut (
    .clk_i(clk), .arst_i(arst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe_o(sda_oe),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .busy_o(busy), .debug_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // AXIS monitors
  always @(posedge clk) begin
    if (m_tvalid && m_tready) begin
      beats <= beats + 1;
      last_beat <= m_tdata;
      got_q.push_back(m_tdata);
    end
    if (s_tready) treadies <= treadies + 1;
    if (sda_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    sda_m = b;
    wait_q(Q);
    scl_m = 1'b1;
    wait_q(Q);
    seen = sda_bus;
    wait_q(Q);
    scl_m = 1'b0;
    wait_q(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q(Q);
    scl_m = 1'b1; wait_q(Q);
    sda_m = 1'b0; wait_q(Q);
    scl_m = 1'b0; wait_q(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q(Q);
    scl_m = 1'b1; wait_q(Q);
    sda_m = 1'b1; wait_q(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(~mack, s);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_beats;
    logic [7:0] exp_tdata;
    logic       exp_drive;
  } wr_vec_t;

  wr_vec_t vecs[5];

  initial begin
    logic       a, d, s;
    logic [7:0] rd;
    int b0, o0, r0;

    vecs[0] = '{8'hA0, 8'h3C, 1'b1, 1'b1, 1, 8'h3C, 1'b1};
    vecs[1] = '{8'h84, 8'h11, 1'b0, 1'b0, 0, 8'h3C, 1'b0};
    vecs[2] = '{8'hA0, 8'h00, 1'b1, 1'b1, 1, 8'h00, 1'b1};
    vecs[3] = '{8'h42, 8'h77, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    vecs[4] = '{8'hA0, 8'hFF, 1'b1, 1'b1, 1, 8'hFF, 1'b1};

    // Reset values
    wait_q(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    arst = 1'b0;
    wait_q(4);

    // Table: address + one data byte + STOP, m_tready high
    for (int i = 0; i < 5; i++) begin
      b0 = beats;
      o0 = oe_cycles;
      i2c_start();
      write_byte(vecs[i].addr, a);
      check($sformatf("v%0d_addr_ack", i), a, vecs[i].exp_aack);
      check($sformatf("v%0d_busy_mid", i), busy, vecs[i].exp_aack);
      write_byte(vecs[i].data, d);
      check($sformatf("v%0d_data_ack", i), d, vecs[i].exp_dack);
      i2c_stop();
      if (vecs[i].exp_beats == 1) exp_q.push_back(vecs[i].data);
      check($sformatf("v%0d_beats", i), beats - b0, vecs[i].exp_beats);
      check($sformatf("v%0d_tdata", i), last_beat, vecs[i].exp_tdata);
      check($sformatf("v%0d_drive", i), (oe_cycles != o0), vecs[i].exp_drive);
      check($sformatf("v%0d_busy_end", i), busy, 0);
      check($sformatf("v%0d_state_end", i), dbg_state, ST_IDLE);
    end

    // STOP in the middle of a data byte discards it
    b0 = beats;
    i2c_start();
    write_byte(8'hA0, a);
    for (int i = 0; i < 4; i++) clock_bit(i[0], s);
    i2c_stop();
    check("partial_beats", beats - b0, 0);
    check("partial_tvalid", m_tvalid, 0);
    check("partial_state", dbg_state, ST_IDLE);

    // Backpressure: first byte held, second NACKed and dropped
    m_tready = 1'b0;
    b0 = beats;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h11, d);
    check("bp_ack1", d, 1);
    check("bp_tvalid", m_tvalid, 1);
    check("bp_tdata1", m_tdata, 8'h11);
    write_byte(8'h22, d);
    check("bp_nack2", d, 0);
    check("bp_tdata2", m_tdata, 8'h11);
    i2c_stop();
    check("bp_hold_tvalid", m_tvalid, 1);
    exp_q.push_back(8'h11);
    m_tready = 1'b1;
    wait_q(2);
    check("bp_beats", beats - b0, 1);
    check("bp_beat_data", last_beat, 8'h11);
    check("bp_tvalid_clr", m_tvalid, 0);

    // Read with data available, controller NACK
    s_tdata = 8'h5A;
    s_tvalid = 1'b1;
    r0 = treadies;
    i2c_start();
    write_byte(8'hA1, a);
    check("rd1_addr_ack", a, 1);
    read_byte(1'b0, rd);
    s_tvalid = 1'b0;
    check("rd1_data", rd, 8'h5A);
    check("rd1_treadies", treadies - r0, 1);
    check("rd1_state_ign", dbg_state, ST_IGN);
    check("rd1_busy", busy, 0);
    wait_q(4 * Q);
    check("rd1_state_hold", dbg_state, ST_IGN);
    check("rd1_oe", sda_oe, 0);
    i2c_stop();
    check("rd1_state_end", dbg_state, ST_IDLE);

    // Read with no data: two 0xFF bytes, s_tready never raised
    r0 = treadies;
    i2c_start();
    write_byte(8'hA1, a);
    check("rd2_addr_ack", a, 1);
    read_byte(1'b1, rd);
    check("rd2_byte0", rd, 8'hFF);
    check("rd2_state_ack", dbg_state, ST_RD);
    read_byte(1'b0, rd);
    check("rd2_byte1", rd, 8'hFF);
    check("rd2_treadies", treadies - r0, 0);
    check("rd2_state_ign", dbg_state, ST_IGN);
    i2c_stop();

    // Repeated START from write into read, then reset mid-read
    b0 = beats;
    r0 = treadies;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h77, d);
    check("rs_data_ack", d, 1);
    exp_q.push_back(8'h77);
    s_tdata = 8'h3C;
    s_tvalid = 1'b1;
    i2c_start();
    write_byte(8'hA1, a);
    s_tvalid = 1'b0;
    check("rs_addr_ack", a, 1);
    check("rs_beats", beats - b0, 1);
    check("rs_beat_data", last_beat, 8'h77);
    check("rs_state_rd", dbg_state, ST_RD);
    check("rs_busy", busy, 1);
    check("rs_treadies", treadies - r0, 1);
    check("rs_oe_msb", sda_oe, 1);
    #2 arst = 1'b1;
    #1 check("rst_mid_oe", sda_oe, 0);
    wait_q(2);
    arst = 1'b0;
    for (int i = 0; i < 3; i++) clock_bit(1'b0, s);
    check("post_rst_state", dbg_state, ST_IDLE);
    check("post_rst_oe", sda_oe, 0);
    check("post_rst_busy", busy, 0);

    // Fresh transaction after reset
    b0 = beats;
    i2c_start();
    write_byte(8'hA0, a);
    check("fresh_addr_ack", a, 1);
    write_byte(8'h55, d);
    check("fresh_data_ack", d, 1);
    i2c_stop();
    exp_q.push_back(8'h55);
    check("fresh_beats", beats - b0, 1);
    check("fresh_beat_data", last_beat, 8'h55);

    // Scoreboard: every AXIS write beat in order
    wait_q(4);
    check("sb_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("sb_beat%0d", i), got_q[i], exp_q[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_i2c_slave.md
AXIS_I2C_SLAVE -- requirements
Module: axis_i2c_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: AXIS tdata width; only bits [7:0] carry I2C data, upper bits zero on output and ignored on input.
REQ-002 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit I2C address this block answers to.
REQ-003 SHALL have port clk_i, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port arst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port scl_i, input, 1: I2C SCL from pad, asynchronous to clk_i.
REQ-006 SHALL have port sda_i, input, 1: I2C SDA from pad, asynchronous to clk_i.
REQ-007 SHALL have port sda_oe_o, input-side pad control, output, 1: 1 = drive SDA low, 0 = release (open-drain).
REQ-008 SHALL have ports m_tdata (out, DATA_WIDTH), m_tvalid (out, 1), m_tready (in, 1): AXIS master carrying bytes written by the I2C controller.
REQ-009 SHALL have ports s_tdata (in, DATA_WIDTH), s_tvalid (in, 1), s_tready (out, 1): AXIS slave supplying bytes returned on I2C reads.
REQ-010 SHALL have port busy_o, output, 1: high from addressed START until STOP or NACK-exit.

Function
REQ-011 SHALL pass scl_i/sda_i through 2-flop synchronizers, then one history flop; edges detected on synchronized values (3-cycle input latency).
REQ-012 SHALL detect START as SDA falling while SCL high, STOP as SDA rising while SCL high, in every state.
REQ-013 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-014 START (incl. repeated START) in any state SHALL go to ADDR with bit counter = 0; STOP in any state SHALL go to IDLE.
REQ-015 SHALL sample SDA on SCL rising edges, MSB first; SHALL change sda_oe_o only on SCL falling edges.
REQ-016 ADDR: after 8 bits, if addr[7:1]==SLAVE_ADDR go to ADDR_ACK and drive ACK (sda_oe_o=1) for the 9th clock; else go to IGNORE with SDA released.
REQ-017 From ADDR_ACK, on the SCL falling edge ending the 9th clock: R/W=0 -> WR_DATA, R/W=1 -> RD_DATA.
REQ-018 WR_DATA: on 8th rising edge, if m_tvalid==0 or m_tready==1 that cycle, load byte into m_tdata, set m_tvalid=1 next cycle, ACK 9th clock; else drop byte and NACK.
REQ-019 m_tvalid SHALL stay high with m_tdata stable until m_tready sampled high; clears the cycle after the handshake.
REQ-020 After WR_ACK (ACK or NACK) falling edge SHALL return to WR_DATA for the next byte.
REQ-021 RD_DATA entry (falling edge): if s_tvalid=1, pulse s_tready for exactly 1 cycle and load s_tdata[7:0]; else load 8'hFF and leave s_tready low.
REQ-022 RD_DATA SHALL drive sda_oe_o = ~bit for 8 bits, then release SDA and enter RD_ACK.
REQ-023 RD_ACK: controller ACK (SDA=0 at rising edge) -> RD_DATA with next byte; NACK -> IGNORE.
REQ-024 IGNORE SHALL keep SDA released and leave only on START/STOP.
REQ-025 busy_o SHALL be 1 in ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK; 0 otherwise.
REQ-026 STOP or START mid-byte SHALL discard the partial byte; a completed byte already in m_tdata SHALL remain valid.

Reset
REQ-027 While arst_i=1: state IDLE, sda_oe_o=0, m_tvalid=0, m_tdata=0, s_tready=0, busy_o=0, counters 0, synchronizers loaded with 1.
REQ-028 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); after release, block waits for a fresh START.

Verification
REQ-029 Write 0xA0, 0x3C, STOP with m_tready=1 -> ACK on both bytes, one beat m_tdata=0x3C, busy_o falls after STOP.
REQ-030 Address 0x42 (non-match) -> sda_oe_o stays 0 for whole transaction, no m_tvalid, busy_o=0.
REQ-031 Write 0xA0, 0x11, 0x22 with m_tready=0 -> 0x11 ACKed and held, 0x22 NACKed and dropped, m_tdata stays 0x11.
REQ-032 Read 0xA1 with s_tdata=0x5A valid, controller NACK -> SDA carries 0x5A, one s_tready pulse, state IGNORE until STOP.
REQ-033 Read 0xA1 with s_tvalid=0 for two bytes (ACK then NACK) -> both bytes 0xFF, s_tready never high.
REQ-034 Repeated START after write byte 0x77, then read 0xA1 -> 0x77 delivered on AXIS, read phase entered without STOP; arst_i mid-read -> sda_oe_o=0 same cycle.
